// File: rtl/unireg_sched_if.sv
// unireg_sched_if: client handshakes plus universal-register control/observe bus
interface unireg_sched_if #(parameter int WIDTH = 4);
   localparam int CW = $clog2(WIDTH + 1);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_data, req1_data;
   logic [CW-1:0]    req0_cnt, req1_cnt;
   logic [1:0]       sel;
   logic             lshift;
   logic [WIDTH-1:0] pload, qout, result;
   logic             done, done_id;
   modport master (
      output req0_valid, req0_op, req0_data, req0_cnt,
      output req1_valid, req1_op, req1_data, req1_cnt, qout,
      input  req0_ready, req1_ready, sel, lshift, pload, done, done_id, result
   );
   modport slave (
      input  req0_valid, req0_op, req0_data, req0_cnt,
      input  req1_valid, req1_op, req1_data, req1_cnt, qout,
      output req0_ready, req1_ready, sel, lshift, pload, done, done_id, result
   );
endinterface

// File: rtl/unireg_sched.sv
// unireg_sched: two-requester sequencer for a universal register; UNIREG_SCHED_FIXPRI_EN selects fixed priority (req0 wins ties)
module unireg_sched #(parameter int WIDTH = 4) (
   input logic           clk,
   input logic           rst,
   unireg_sched_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, EXEC, FIN} st_t;
   st_t              st, nst;
   logic [1:0]       op_q, op_w;
   logic [WIDTH-1:0] data_q, res_q;
   logic [CW-1:0]    cnt_q, k, eff, cnt_w;
   logic             id_q, g0, g1, gnt;
`ifdef UNIREG_SCHED_FIXPRI_EN
   assign g1 = bus.req1_valid & ~bus.req0_valid;
`else
   logic last;
   assign g1 = bus.req1_valid & (~bus.req0_valid | ~last);
   // remember the last granted requester so the other one wins the next tie
   always_ff @(posedge clk)
      if (rst) last <= 1'b1;
      else if (gnt) last <= g1;
`endif
   assign g0    = bus.req0_valid & ~g1;
   assign gnt   = (st == IDLE) & ~rst & (bus.req0_valid | bus.req1_valid);
   assign op_w  = g1 ? bus.req1_op : bus.req0_op;
   assign cnt_w = g1 ? bus.req1_cnt : bus.req0_cnt;
   assign eff   = (op_w == 2'd0 || op_w == 2'd3) ? CW'(1) : (cnt_w > CW'(WIDTH) ? CW'(WIDTH) : cnt_w);
   // state register
   always_ff @(posedge clk)
      if (rst) st <= IDLE;
      else st <= nst;
   // capture the winning command, count steps, keep the last result
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         id_q   <= 1'b0;
         k      <= '0;
         res_q  <= '0;
      end else begin
         if (gnt) begin
            op_q   <= op_w;
            data_q <= g1 ? bus.req1_data : bus.req0_data;
            cnt_q  <= eff;
            id_q   <= g1;
            k      <= '0;
         end else if (st == EXEC) k <= k + CW'(1);
         if (st == FIN) res_q <= bus.qout;
      end
   end
   // next-state logic
   always_comb
      nst = st == IDLE ? (gnt ? (eff == '0 ? FIN : EXEC) : IDLE) :
            st == EXEC ? (k == cnt_q - CW'(1) ? FIN : EXEC) : IDLE;
   // register controls, grants and completion report
   always_comb begin
      bus.req0_ready = gnt & g0;
      bus.req1_ready = gnt & g1;
      bus.sel        = st != EXEC ? 2'd3 : op_q == 2'd0 ? 2'd1 : op_q == 2'd3 ? 2'd2 : 2'd0;
      bus.lshift     = st != EXEC ? 1'b0 :
                       op_q == 2'd1 ? 1'(data_q >> (cnt_q - CW'(1) - k)) :
                       op_q == 2'd2 ? bus.qout[WIDTH-1] : 1'b0;
      bus.pload      = (st == EXEC && op_q == 2'd0) ? data_q : '0;
      bus.done       = st == FIN;
      bus.done_id    = (st == FIN) & id_q;
      bus.result     = st == FIN ? bus.qout : res_q;
   end
endmodule
